// File: rtl/change_capture_pkg.sv
// Shared types and sizing helpers for the change-capture FIFO.
// The drop counter option is controlled by CHANGE_CAPTURE_DROP_COUNT_EN, which the top level checks.
package change_capture_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int TS_W_DEF   = 16;
  localparam int DEPTH_DEF  = 8;

  typedef struct packed {
    logic [TS_W_DEF-1:0]   ts;
    logic [DATA_W_DEF-1:0] q;
    logic [DATA_W_DEF-1:0] d;
  } cap_rec_t;

  // The occupancy counter must be able to hold DEPTH itself, not just DEPTH-1.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cap_fifo.sv
// Generic synchronous first-word-fall-through FIFO of capture records.
// Head data reads as zero while the FIFO is empty.
module cap_fifo
  import change_capture_pkg::*;
#(
  parameter type rec_t = cap_rec_t,
  parameter int  DEPTH = DEPTH_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  rec_t                      wr_data,
  input  logic                      pop,
  output rec_t                      rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [count_w(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the push writes into.
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? rec_t'('0) : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_capture_fifo.sv
// Value-change monitor for a q/d register pair: timestamped records go into a FWFT FIFO.
// Defining CHANGE_CAPTURE_DROP_COUNT_EN adds a saturating drop_count output.
module change_capture_fifo
  import change_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         q_in,
  input  logic [DATA_W-1:0]         d_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_W-1:0]           out_ts,
  output logic [DATA_W-1:0]         out_q,
  output logic [DATA_W-1:0]         out_d,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      overflow
`ifdef CHANGE_CAPTURE_DROP_COUNT_EN
  ,
  output logic [7:0]                drop_count
`endif
);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] d;
  } rec_t;

  logic [TS_W-1:0]   ts_now;
  logic              armed;
  logic [DATA_W-1:0] q_prev;
  logic [DATA_W-1:0] d_prev;
  logic              push_evt;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  rec_t              new_rec;
  rec_t              head;

  assign push_evt  = armed && ((q_in != q_prev) || (d_in != d_prev));
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = push_evt && fifo_full && !pop;
  assign new_rec   = '{ts: ts_now, q: q_in, d: d_in};
  assign out_ts    = head.ts;
  assign out_q     = head.q;
  assign out_d     = head.d;

  // The first cycle out of reset only captures the baseline, since armed is still low.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_now <= '0;
      armed  <= 1'b0;
      q_prev <= '0;
      d_prev <= '0;
    end else begin
      ts_now <= ts_now + 1'b1;
      armed  <= 1'b1;
      q_prev <= q_in;
      d_prev <= d_in;
    end
  end

`ifdef CHANGE_CAPTURE_DROP_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  assign overflow = (drop_count != 8'h00);
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end
`endif

  cap_fifo #(
    .rec_t (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_evt),
    .wr_data (new_rec),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

endmodule

// File: tb/tb_change_capture_fifo.sv
// Randomized bench for change_capture_fifo against a queue-based reference model.
module tb_change_capture_fifo;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  q_in;
  logic [3:0]  d_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ts;
  logic [3:0]  out_q;
  logic [3:0]  out_d;
  logic [3:0]  count;
  logic        overflow;
`ifdef CHANGE_CAPTURE_DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  change_capture_fifo #(
    .DATA_W (4),
    .TS_W   (16),
    .DEPTH  (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .q_in      (q_in),
    .d_in      (d_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ts    (out_ts),
    .out_q     (out_q),
    .out_d     (out_d),
    .count     (count),
    .overflow  (overflow)
`ifdef CHANGE_CAPTURE_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] ts;
    logic [3:0]  q;
    logic [3:0]  d;
  } mrec_t;

  mrec_t       mq[$];
  logic [15:0] m_ts;
  bit          m_armed;
  logic [3:0]  m_qp;
  logic [3:0]  m_dp;
  bit          m_ovf;
  int          m_drops;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; advances model and DUT by one clock.
  task automatic step(input bit do_chk = 1'b1);
    mrec_t r;
    bit    pop_m;
    bit    push_m;
    if (reset) begin
      mq.delete();
      m_ts    = '0;
      m_armed = 0;
      m_ovf   = 0;
      m_drops = 0;
    end else begin
      pop_m  = (mq.size() > 0) && out_ready;
      push_m = m_armed && ((q_in != m_qp) || (d_in != m_dp));
      r.ts = m_ts;
      r.q  = q_in;
      r.d  = d_in;
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        if (mq.size() < DEPTH) mq.push_back(r);
        else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
      end
      m_qp    = q_in;
      m_dp    = d_in;
      m_armed = 1;
      m_ts    = m_ts + 16'd1;
    end
    @(posedge clock);
    #1;
    if (do_chk) begin
      chk("valid", out_valid, mq.size() > 0);
      chk("count", count, mq.size());
      chk("overflow", overflow, m_ovf);
`ifdef CHANGE_CAPTURE_DROP_COUNT_EN
      chk("drop_count", drop_count, m_drops);
`endif
      if (mq.size() > 0) begin
        chk("head_ts", out_ts, mq[0].ts);
        chk("head_q", out_q, mq[0].q);
        chk("head_d", out_d, mq[0].d);
      end
    end
    @(negedge clock);
  endtask

  initial begin
    logic [15:0] t;
    reset     = 1'b1;
    q_in      = '0;
    d_in      = '0;
    out_ready = 1'b1;
    @(negedge clock);

    // reset state
    step();
    step();
    chk("rst_ts", out_ts, 0);
    chk("rst_q", out_q, 0);
    chk("rst_d", out_d, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) step();
    chk("idle_valid", out_valid, 0);

    // d change, then the register copies it to q
    t    = m_ts;
    d_in = 4'h1;
    step();
    chk("rec1_ts", out_ts, t);
    chk("rec1_q", out_q, 4'h0);
    chk("rec1_d", out_d, 4'h1);
    q_in = 4'h1;
    step();
    chk("rec2_ts", out_ts, t + 16'd1);
    chk("rec2_q", out_q, 4'h1);
    step();
    chk("drain_empty", out_valid, 0);

    // simultaneous q and d change gives one record
    d_in = 4'hF;
    q_in = 4'h7;
    step();
    chk("simul_count", count, 1);
    step();
    chk("simul_single", out_valid, 0);

    // fill past DEPTH with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d_in = d_in + 4'd1;
      step();
    end
    chk("full_count", count, 8);
    chk("full_ovf", overflow, 1);
`ifdef CHANGE_CAPTURE_DROP_COUNT_EN
    chk("full_drops", drop_count, 2);
`endif

    // pop and push together while full
    out_ready = 1'b1;
    d_in      = d_in + 4'd1;
    step();
    chk("full_pp_count", count, 8);
`ifdef CHANGE_CAPTURE_DROP_COUNT_EN
    chk("full_pp_drops", drop_count, 2);
`endif
    for (int i = 0; i < 10; i++) step();
    chk("drained", count, 0);

    // reset with records queued, then change on the baseline cycle
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q_in = q_in + 4'd1;
      step();
    end
    chk("pre_rst_count", count, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    d_in  = d_in + 4'd3;
    step();
    chk("post_rst_count", count, 0);
    chk("post_rst_ovf", overflow, 0);
    step();
    chk("baseline_norec", out_valid, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) d_in = 4'($urandom);
      if ($urandom_range(0, 3) == 0) q_in = d_in;
      out_ready = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step();
    end

    // timestamp wrap
    reset     = 1'b1;
    out_ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 70000 && m_ts != 16'hFFFF; i++) step(1'b0);
    d_in = d_in + 4'd1;
    step();
    chk("wrap_ts0", out_ts, 16'hFFFF);
    d_in = d_in + 4'd1;
    step();
    chk("wrap_count", count, 2);
    out_ready = 1'b1;
    step();
    chk("wrap_ts1", out_ts, 16'h0000);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
